// File: rtl/fetch_stage.sv
// ============================================================================
// fetch_stage
// ----------------------------------------------------------------------------
// Instruction-fetch stage of the rv32i pipeline. It holds the program counter
// and drives it to the combinational instruction memory. The word that comes
// back is captured into the IF/ID pipeline register.
//
// The stage also handles:
//   - stalls and flushes from the hazard unit,
//   - redirects from EX for taken branches, jal and jalr,
//   - parking fetch once an EBREAK reaches decode.
//
// Ports:
//   clk        - rising-edge clock
//   reset      - asynchronous, active-high reset
//   StallF     - hold the PC
//   StallD     - hold the IF/ID register
//   FlushD     - replace the IF/ID contents with a bubble
//   PCSrcE     - EX-stage redirect request
//   PCTargetE  - redirect target address
//   InstrF     - instruction word for PCF, returned in the same cycle
//   PCF        - fetch address to instruction memory
//   InstrD     - IF/ID instruction
//   PCD        - IF/ID PC
//   PCPlus4D   - IF/ID PC+4
//   ValidD     - IF/ID holds a real instruction (or a fault marker)
//   FaultD     - IF/ID slot came from a misaligned or out-of-range fetch
//   HaltedF    - fetch is parked after an EBREAK
// ============================================================================
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 2048
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    input  logic [31:0] InstrF,
    output logic [31:0] PCF,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD,
    output logic        FaultD,
    output logic        HaltedF
);

    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
    localparam logic [31:0] EBREAK_INSTR = 32'h0010_0073;

    // Word-index bound used to detect fetches that fall past the end of memory.
    localparam logic [29:0] IMEM_LIMIT = 30'(IMEM_WORDS);

    logic [1:0]  state_q,  state_d;
    logic [31:0] pc_q,     pc_d;
    logic [31:0] instr_q,  instr_d;
    logic [31:0] pcd_q,    pcd_d;
    logic [31:0] pcp4_q,   pcp4_d;
    logic        valid_q,  valid_d;
    logic        fault_q,  fault_d;

    logic [31:0] pc_plus4;
    logic        fetch_fault;

    // Next-state logic for the PC, the boot/run/halt FSM and the IF/ID register.
    //
    // A redirect always squashes whatever is being fetched, because the fetch
    // is on the wrong path. During BOOT the PC is pinned to RESET_PC for one
    // cycle, so the first real fetch happens one cycle after reset releases.
    always_comb begin
        pc_plus4    = pc_q + 32'd4;
        fetch_fault = (pc_q[1:0] != 2'b00) || (pc_q[31:2] >= IMEM_LIMIT);

        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        pcd_d   = pcd_q;
        pcp4_d  = pcp4_q;
        valid_d = valid_q;
        fault_d = fault_q;

        // PC and FSM
        if (state_q == ST_BOOT) begin
            pc_d    = RESET_PC;
            state_d = ST_RUN;
        end else if (PCSrcE) begin
            pc_d = PCTargetE;
            if (state_q == ST_HALT) begin
                state_d = ST_RUN;
            end
        end else if (StallF || (state_q == ST_HALT)) begin
            pc_d = pc_q;
        end else begin
            pc_d = pc_plus4;
        end

        // IF/ID register
        if ((state_q == ST_BOOT) || FlushD || PCSrcE) begin
            instr_d = NOP_INSTR;
            pcd_d   = 32'd0;
            pcp4_d  = 32'd0;
            valid_d = 1'b0;
            fault_d = 1'b0;
        end else if (StallD) begin
            instr_d = instr_q;
        end else if (state_q == ST_HALT) begin
            instr_d = NOP_INSTR;
            pcd_d   = 32'd0;
            pcp4_d  = 32'd0;
            valid_d = 1'b0;
            fault_d = 1'b0;
        end else if (fetch_fault) begin
            // The fault is passed down as a marked slot so a later stage can
            // raise the exception. The fetched word itself is not trusted.
            instr_d = NOP_INSTR;
            pcd_d   = pc_q;
            pcp4_d  = pc_plus4;
            valid_d = 1'b1;
            fault_d = 1'b1;
        end else begin
            instr_d = InstrF;
            pcd_d   = pc_q;
            pcp4_d  = pc_plus4;
            valid_d = 1'b1;
            fault_d = 1'b0;
            if (InstrF == EBREAK_INSTR) begin
                state_d = ST_HALT;
            end
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            pcd_q   <= 32'd0;
            pcp4_q  <= 32'd0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pcd_q   <= pcd_d;
            pcp4_q  <= pcp4_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
        end
    end

    assign PCF      = pc_q;
    assign InstrD   = instr_q;
    assign PCD      = pcd_q;
    assign PCPlus4D = pcp4_q;
    assign ValidD   = valid_q;
    assign FaultD   = fault_q;
    assign HaltedF  = (state_q == ST_HALT);

endmodule

// File: tb/tb_fetch_stage.sv
// ============================================================================
// tb_fetch_stage
// ----------------------------------------------------------------------------
// Scoreboard bench for fetch_stage.
//
// Expected outputs for the cycle after each clock edge are queued while the
// stimulus is set up. They are popped and compared once the DUT has updated.
//
// Instruction memory is modelled combinationally:
//   - each word encodes its own address,
//   - an EBREAK can be planted at 0x10.
// ============================================================================
module tb_fetch_stage;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    localparam int S_PCF    = 0;
    localparam int S_INSTRD = 1;
    localparam int S_PCD    = 2;
    localparam int S_PCP4D  = 3;
    localparam int S_VALIDD = 4;
    localparam int S_FAULTD = 5;
    localparam int S_HALTED = 6;

    typedef struct {
        string       tag;
        int          sig;
        logic [31:0] value;
    } expect_t;

    logic        clk;
    logic        reset;
    logic        StallF, StallD, FlushD, PCSrcE;
    logic [31:0] PCTargetE;
    logic [31:0] InstrF;
    logic [31:0] PCF, InstrD, PCD, PCPlus4D;
    logic        ValidD, FaultD, HaltedF;
    logic        ebreakEn;

    expect_t scoreboard[$];
    int      errorCount = 0;
    int      checkCount = 0;

    fetch_stage dut (
        .clk       (clk),
        .reset     (reset),
        .StallF    (StallF),
        .StallD    (StallD),
        .FlushD    (FlushD),
        .PCSrcE    (PCSrcE),
        .PCTargetE (PCTargetE),
        .InstrF    (InstrF),
        .PCF       (PCF),
        .InstrD    (InstrD),
        .PCD       (PCD),
        .PCPlus4D  (PCPlus4D),
        .ValidD    (ValidD),
        .FaultD    (FaultD),
        .HaltedF   (HaltedF)
    );

    // Memory word for an address: {addr[23:0], 8'h93}. An EBREAK sits at
    // 0x10 only while ebreakEn is set.
    function automatic logic [31:0] memWord(input logic [31:0] addr);
        if (ebreakEn && addr == 32'h10) return EBREAK;
        return {addr[23:0], 8'h93};
    endfunction

    assign InstrF = memWord(PCF);

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run always ends even if the bench itself stalls.
    initial begin
        #20000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point; every check in the bench goes through here.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: actual=%h expected=%h", tag, actual, expected);
        end
    endtask

    function automatic logic [31:0] observed(input int sig);
        case (sig)
            S_PCF:    return PCF;
            S_INSTRD: return InstrD;
            S_PCD:    return PCD;
            S_PCP4D:  return PCPlus4D;
            S_VALIDD: return {31'd0, ValidD};
            S_FAULTD: return {31'd0, FaultD};
            S_HALTED: return {31'd0, HaltedF};
            default:  return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic expectOut(input string tag, input int sig, input logic [31:0] value);
        expect_t e;
        e.tag   = tag;
        e.sig   = sig;
        e.value = value;
        scoreboard.push_back(e);
    endtask

    // Queue the expected IF/ID contents for a real fetch from addr.
    task automatic expectFetch(input string tag, input logic [31:0] addr);
        expectOut({tag, ".instr"}, S_INSTRD, memWord(addr));
        expectOut({tag, ".pcd"},   S_PCD,    addr);
        expectOut({tag, ".pcp4"},  S_PCP4D,  addr + 32'd4);
        expectOut({tag, ".valid"}, S_VALIDD, 32'd1);
        expectOut({tag, ".fault"}, S_FAULTD, 32'd0);
    endtask

    task automatic expectBubble(input string tag);
        expectOut({tag, ".instr"}, S_INSTRD, NOP);
        expectOut({tag, ".valid"}, S_VALIDD, 32'd0);
        expectOut({tag, ".fault"}, S_FAULTD, 32'd0);
    endtask

    // Drive inputs for the coming edge, let it pass, then drain the scoreboard.
    task automatic applyStimulus(input logic stallF, input logic stallD,
                                 input logic flushD, input logic pcSrcE,
                                 input logic [31:0] target);
        expect_t e;
        StallF    = stallF;
        StallD    = stallD;
        FlushD    = flushD;
        PCSrcE    = pcSrcE;
        PCTargetE = target;
        @(posedge clk);
        #1;
        while (scoreboard.size() > 0) begin
            e = scoreboard.pop_front();
            checkOutput(e.tag, observed(e.sig), e.value);
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, ".pcf"},    PCF,               32'h0);
        checkOutput({tag, ".instr"},  InstrD,            NOP);
        checkOutput({tag, ".pcd"},    PCD,               32'h0);
        checkOutput({tag, ".pcp4"},   PCPlus4D,          32'h0);
        checkOutput({tag, ".valid"},  {31'd0, ValidD},   32'd0);
        checkOutput({tag, ".fault"},  {31'd0, FaultD},   32'd0);
        checkOutput({tag, ".halted"}, {31'd0, HaltedF},  32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        StallF    = 1'b0;
        StallD    = 1'b0;
        FlushD    = 1'b0;
        PCSrcE    = 1'b0;
        PCTargetE = 32'h0;
        ebreakEn  = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        checkResetState("reset");
        reset = 1'b0;

        // Boot: PC pinned for one cycle, first real fetch lands two cycles in
        expectOut("boot1.pcf", S_PCF, 32'h0);
        expectBubble("boot1");
        applyStimulus(0, 0, 0, 0, 32'h0);
        expectOut("boot2.pcf", S_PCF, 32'h4);
        expectFetch("boot2", 32'h0);
        applyStimulus(0, 0, 0, 0, 32'h0);
        expectOut("run.pcf", S_PCF, 32'h8);
        expectFetch("run", 32'h4);
        applyStimulus(0, 0, 0, 0, 32'h0);

        // Stall both stages for three cycles at PCF=8
        for (int i = 0; i < 3; i++) begin
            expectOut("stall.pcf", S_PCF, 32'h8);
            expectFetch("stall", 32'h4);
            applyStimulus(1, 1, 0, 0, 32'h0);
        end
        expectOut("resume.pcf", S_PCF, 32'hC);
        expectFetch("resume", 32'h8);
        applyStimulus(0, 0, 0, 0, 32'h0);

        // Redirect overrides StallF
        expectOut("redir.pcf", S_PCF, 32'h40);
        expectBubble("redir");
        applyStimulus(1, 0, 0, 1, 32'h40);
        expectOut("redir2.pcf", S_PCF, 32'h44);
        expectFetch("redir2", 32'h40);
        applyStimulus(0, 0, 0, 0, 32'h0);

        // FlushD beats StallD
        expectOut("flush.pcf", S_PCF, 32'h48);
        expectBubble("flush");
        applyStimulus(0, 1, 1, 0, 32'h0);
        expectOut("flush2.pcf", S_PCF, 32'h4C);
        expectFetch("flush2", 32'h48);
        applyStimulus(0, 0, 0, 0, 32'h0);

        // EBREAK at 0x10 parks fetch until a redirect
        ebreakEn = 1'b1;
        expectOut("ebr0.pcf", S_PCF, 32'h10);
        expectOut("ebr0.halted", S_HALTED, 32'd0);
        applyStimulus(0, 0, 0, 1, 32'h10);
        expectOut("ebr1.pcf", S_PCF, 32'h14);
        expectOut("ebr1.halted", S_HALTED, 32'd1);
        expectFetch("ebr1", 32'h10);
        applyStimulus(0, 0, 0, 0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            expectOut("halt.pcf", S_PCF, 32'h14);
            expectOut("halt.halted", S_HALTED, 32'd1);
            expectBubble("halt");
            applyStimulus(0, 0, 0, 0, 32'h0);
        end
        expectOut("unhalt.pcf", S_PCF, 32'h20);
        expectOut("unhalt.halted", S_HALTED, 32'd0);
        expectBubble("unhalt");
        applyStimulus(0, 0, 0, 1, 32'h20);
        expectOut("unhalt2.pcf", S_PCF, 32'h24);
        expectFetch("unhalt2", 32'h20);
        applyStimulus(0, 0, 0, 0, 32'h0);
        ebreakEn = 1'b0;

        // Misaligned redirect target: marked fault slots, PC keeps advancing
        expectOut("mis0.pcf", S_PCF, 32'h22);
        applyStimulus(0, 0, 0, 1, 32'h22);
        expectOut("mis1.pcf", S_PCF, 32'h26);
        expectOut("mis1.valid", S_VALIDD, 32'd1);
        expectOut("mis1.fault", S_FAULTD, 32'd1);
        expectOut("mis1.instr", S_INSTRD, NOP);
        expectOut("mis1.pcd", S_PCD, 32'h22);
        applyStimulus(0, 0, 0, 0, 32'h0);

        // Last in-range word, then first out-of-range word (2048*4 = 0x2000)
        expectOut("edge0.pcf", S_PCF, 32'h1FFC);
        applyStimulus(0, 0, 0, 1, 32'h1FFC);
        expectOut("edge1.pcf", S_PCF, 32'h2000);
        expectFetch("edge1", 32'h1FFC);
        applyStimulus(0, 0, 0, 0, 32'h0);
        expectOut("oor.pcf", S_PCF, 32'h2004);
        expectOut("oor.valid", S_VALIDD, 32'd1);
        expectOut("oor.fault", S_FAULTD, 32'd1);
        expectOut("oor.pcd", S_PCD, 32'h2000);
        applyStimulus(0, 0, 0, 0, 32'h0);

        // PC+4 wraps past the top of the address space
        expectOut("wrap0.pcf", S_PCF, 32'hFFFF_FFFC);
        applyStimulus(0, 0, 0, 1, 32'hFFFF_FFFC);
        expectOut("wrap1.pcf", S_PCF, 32'h0);
        expectOut("wrap1.pcd", S_PCD, 32'hFFFF_FFFC);
        expectOut("wrap1.pcp4", S_PCP4D, 32'h0);
        expectOut("wrap1.fault", S_FAULTD, 32'd1);
        applyStimulus(0, 0, 0, 0, 32'h0);
        expectOut("wrap2.pcf", S_PCF, 32'h4);
        expectFetch("wrap2", 32'h0);
        applyStimulus(0, 0, 0, 0, 32'h0);

        // Asynchronous reset between clock edges
        #2;
        reset = 1'b1;
        #1;
        checkResetState("areset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        expectOut("reboot1.pcf", S_PCF, 32'h0);
        expectBubble("reboot1");
        applyStimulus(0, 0, 0, 0, 32'h0);
        expectOut("reboot2.pcf", S_PCF, 32'h4);
        expectFetch("reboot2", 32'h0);
        applyStimulus(0, 0, 0, 0, 32'h0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
